// File: rtl/ask_pkg.sv
// Shared types and helpers for the 4-ASK slicer / MER estimator.
package ask_pkg;

  localparam int SAMPLE_W = 18;

  typedef enum logic [1:0] {
    SYM_M3 = 2'b00,
    SYM_M1 = 2'b01,
    SYM_P1 = 2'b11,
    SYM_P3 = 2'b10
  } sym_t;

  typedef enum logic {ACQ, TRACK} state_t;

  // |x| for a 1s17 sample; -1.0 has no positive twin so it pins to full scale.
  function automatic logic [SAMPLE_W-2:0] abs_sat(input logic signed [SAMPLE_W-1:0] x);
    if (x[SAMPLE_W-1] && (x[SAMPLE_W-2:0] == '0)) return '1;
    else if (x[SAMPLE_W-1]) return (SAMPLE_W-1)'(-x);
    else return x[SAMPLE_W-2:0];
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] clip18(input logic signed [SAMPLE_W:0] x);
    if (x > 19'sd131071) return 18'sh1ffff;
    else if (x < -19'sd131072) return 18'sh20000;
    else return x[SAMPLE_W-1:0];
  endfunction

endpackage

// File: rtl/block_avg_acc.sv
// Saturating block accumulator: adds din on add_en, clears on wrap, and
// presents the block average (acc_next >> LOG2_N) for the wrap cycle.
module block_avg_acc #(
  parameter int W_IN      = 18,
  parameter int W_ACC     = 25,
  parameter int LOG2_N    = 7,
  parameter bit IS_SIGNED = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      add_en,
  input  logic                      wrap,
  input  logic [W_IN-1:0]           din,
  output logic [W_ACC-LOG2_N-1:0]   avg
);

  logic [W_ACC-1:0] acc_q, acc_d, acc_next, din_ext;
  logic [W_ACC:0]   sum;

  always_comb begin
    if (IS_SIGNED) din_ext = W_ACC'($signed(din));
    else           din_ext = W_ACC'(din);
    sum = {1'b0, acc_q} + {1'b0, din_ext};
    // Signed sums are sized so they cannot overflow; unsigned ones pin at all-ones.
    if (IS_SIGNED) acc_next = sum[W_ACC-1:0];
    else           acc_next = sum[W_ACC] ? '1 : sum[W_ACC-1:0];
    acc_d = acc_q;
    if (add_en) acc_d = wrap ? '0 : acc_next;
  end

  assign avg = acc_next[W_ACC-1:LOG2_N];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/ask4_slicer_mer.sv
// Symbol-rate 4-ASK slicer with block threshold estimate and mean-square error.
// Optional DC removal when DC_REMOVE_EN is defined (adds dc_est output).
//   state | meaning
//   ACQ   | threshold held at INIT_REF until the first block completes
//   TRACK | threshold and err_pow refreshed at every block end
module ask4_slicer_mer
  import ask_pkg::*;
#(
  parameter int                  LOG2_N   = 7,
  parameter logic [SAMPLE_W-1:0] INIT_REF = 18'd65536
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sam_clk_en,
  input  logic                       sym_clk_en,
  input  logic                       phase_sel,
  input  logic signed [SAMPLE_W-1:0] x_in,
  output logic [1:0]                 sym_out,
  output logic                       sym_valid,
  output logic [SAMPLE_W-1:0]        ref_level,
  output logic [35:0]                err_pow,
  output logic                       blk_done,
  output logic                       locked
`ifdef DC_REMOVE_EN
  ,
  output logic signed [SAMPLE_W-1:0] dc_est
`endif
);

  logic signed [SAMPLE_W-1:0] x_prev_q, x_prev_d, s_r_q, s_r_d, s_c;
  logic                       s_vld_q, s_vld_d;
  sym_t                       sym_q, sym_d, dec;
  logic                       sym_valid_q, sym_valid_d;
  logic [SAMPLE_W-1:0]        ref_level_q, ref_level_d;
  logic [35:0]                err_pow_q, err_pow_d;
  logic                       blk_done_q, blk_done_d;
  logic                       locked_q, locked_d;
  state_t                     state_q, state_d;
  logic [LOG2_N-1:0]          cnt_q, cnt_d;

  logic signed [SAMPLE_W:0]   s19, t19, b19, lvl, e;
  logic signed [37:0]         e_ext, e_sq_s;
  logic [37:0]                e_sq, sq_avg;
  logic [SAMPLE_W-2:0]        abs_s, abs_avg;
  logic                       wrap;

`ifdef DC_REMOVE_EN
  logic signed [SAMPLE_W-1:0] dc_q, dc_d;
  logic [SAMPLE_W-1:0]        dc_avg;
`endif

  always_comb begin
`ifdef DC_REMOVE_EN
    s_c  = clip18(19'(s_r_q) - 19'(dc_q));
`else
    s_c  = s_r_q;
`endif
    s19  = s_c;
    t19  = $signed({1'b0, ref_level_q});
    b19  = t19 >>> 1;

    // Ties at |s| == t resolve to the outer level.
    if (!s19[SAMPLE_W]) dec = (s19 >= t19) ? SYM_P3 : SYM_P1;
    else                dec = (s19 > -t19) ? SYM_M1 : SYM_M3;

    case (dec)
      SYM_P3:  lvl = t19 + b19;
      SYM_P1:  lvl = b19;
      SYM_M1:  lvl = -b19;
      default: lvl = -(t19 + b19);
    endcase

    e      = s19 - lvl;
    e_ext  = 38'(e);
    e_sq_s = e_ext * e_ext;
    e_sq   = e_sq_s;
    abs_s  = abs_sat(s_c);
    wrap   = s_vld_q && (cnt_q == '1);

    x_prev_d    = sam_clk_en ? x_in : x_prev_q;
    s_vld_d     = sym_clk_en & sam_clk_en;
    s_r_d       = s_vld_d ? (phase_sel ? x_prev_q : x_in) : s_r_q;
    sym_d       = s_vld_q ? dec : sym_q;
    sym_valid_d = s_vld_q;
    cnt_d       = s_vld_q ? cnt_q + LOG2_N'(1) : cnt_q;
    blk_done_d  = wrap;
    state_d     = wrap ? TRACK : state_q;
    locked_d    = (state_d == TRACK);
    ref_level_d = wrap ? {1'b0, abs_avg} : ref_level_q;
    err_pow_d   = err_pow_q;
    if (wrap) err_pow_d = (|sq_avg[37:36]) ? '1 : sq_avg[35:0];
`ifdef DC_REMOVE_EN
    dc_d        = wrap ? dc_avg : dc_q;
`endif
  end

  block_avg_acc #(.W_IN(SAMPLE_W-1), .W_ACC(SAMPLE_W-1+LOG2_N), .LOG2_N(LOG2_N), .IS_SIGNED(1'b0))
    u_abs_acc (.clk(clk), .reset(reset), .add_en(s_vld_q), .wrap(wrap), .din(abs_s), .avg(abs_avg));

  block_avg_acc #(.W_IN(38), .W_ACC(38+LOG2_N), .LOG2_N(LOG2_N), .IS_SIGNED(1'b0))
    u_sq_acc (.clk(clk), .reset(reset), .add_en(s_vld_q), .wrap(wrap), .din(e_sq), .avg(sq_avg));

`ifdef DC_REMOVE_EN
  // DC is estimated from the raw symbol samples, not the corrected ones.
  block_avg_acc #(.W_IN(SAMPLE_W), .W_ACC(SAMPLE_W+LOG2_N), .LOG2_N(LOG2_N), .IS_SIGNED(1'b1))
    u_dc_acc (.clk(clk), .reset(reset), .add_en(s_vld_q), .wrap(wrap), .din(s_r_q), .avg(dc_avg));
  assign dc_est = dc_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_prev_q    <= '0;
      s_r_q       <= '0;
      s_vld_q     <= 1'b0;
      sym_q       <= SYM_M3;
      sym_valid_q <= 1'b0;
      ref_level_q <= INIT_REF;
      err_pow_q   <= '0;
      blk_done_q  <= 1'b0;
      locked_q    <= 1'b0;
      state_q     <= ACQ;
      cnt_q       <= '0;
`ifdef DC_REMOVE_EN
      dc_q        <= '0;
`endif
    end else begin
      x_prev_q    <= x_prev_d;
      s_r_q       <= s_r_d;
      s_vld_q     <= s_vld_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      ref_level_q <= ref_level_d;
      err_pow_q   <= err_pow_d;
      blk_done_q  <= blk_done_d;
      locked_q    <= locked_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
`ifdef DC_REMOVE_EN
      dc_q        <= dc_d;
`endif
    end
  end

  assign sym_out   = sym_q;
  assign sym_valid = sym_valid_q;
  assign ref_level = ref_level_q;
  assign err_pow   = err_pow_q;
  assign blk_done  = blk_done_q;
  assign locked    = locked_q;

  a_sym_needs_sam: assert property (@(posedge clk) disable iff (reset) sym_clk_en |-> sam_clk_en);

endmodule

// File: tb/tb_ask4_slicer_mer.sv
// Directed bench for ask4_slicer_mer with N=16 blocks; DC tests when DC_REMOVE_EN is defined.
module tb_ask4_slicer_mer;

  logic               clk = 1'b0;
  logic               reset, sam_clk_en, sym_clk_en, phase_sel;
  logic signed [17:0] x_in;
  logic [1:0]         sym_out;
  logic               sym_valid, blk_done, locked;
  logic [17:0]        ref_level;
  logic [35:0]        err_pow;
`ifdef DC_REMOVE_EN
  logic signed [17:0] dc_est;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  logic       pend_vld;
  logic [1:0] pend_sym;
  logic       pend_blk;

  logic signed [17:0] ideal_x [4];
  logic [1:0]         ideal_s [4];

  always #5 clk = ~clk;

  ask4_slicer_mer #(.LOG2_N(4), .INIT_REF(18'd65536)) dut (
    .clk(clk), .reset(reset), .sam_clk_en(sam_clk_en), .sym_clk_en(sym_clk_en),
    .phase_sel(phase_sel), .x_in(x_in), .sym_out(sym_out), .sym_valid(sym_valid),
    .ref_level(ref_level), .err_pow(err_pow), .blk_done(blk_done),
`ifdef DC_REMOVE_EN
    .dc_est(dc_est),
`endif
    .locked(locked)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_pending();
    if (pend_vld) begin
      chk("sym_valid", 64'(sym_valid), 64'(1));
      chk("sym_out", 64'(sym_out), 64'(pend_sym));
      chk("blk_done", 64'(blk_done), 64'(pend_blk));
    end
    pend_vld = 1'b0;
  endtask

  // One symbol period (4 clk): off-phase sample a, then on-phase sample b with sym_clk_en.
  task automatic symbol(input logic signed [17:0] a, input logic signed [17:0] b,
                        input logic [1:0] es, input logic eb);
    @(negedge clk);
    check_pending();
    sam_clk_en = 1'b1; sym_clk_en = 1'b0; x_in = a;
    @(negedge clk);
    sam_clk_en = 1'b0;
    @(negedge clk);
    sam_clk_en = 1'b1; sym_clk_en = 1'b1; x_in = b;
    @(negedge clk);
    sam_clk_en = 1'b0; sym_clk_en = 1'b0;
    pend_vld = 1'b1; pend_sym = es; pend_blk = eb;
  endtask

  task automatic flush();
    @(negedge clk);
    check_pending();
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; sam_clk_en = 1'b0; sym_clk_en = 1'b0; pend_vld = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst sym_out", 64'(sym_out), 64'(0));
    chk("rst sym_valid", 64'(sym_valid), 64'(0));
    chk("rst ref_level", 64'(ref_level), 64'(65536));
    chk("rst err_pow", 64'(err_pow), 64'(0));
    chk("rst blk_done", 64'(blk_done), 64'(0));
    chk("rst locked", 64'(locked), 64'(0));
`ifdef DC_REMOVE_EN
    chk("rst dc_est", 64'(dc_est), 64'(0));
`endif
    reset = 1'b0;
  endtask

  initial begin
    logic signed [17:0] v;
    reset = 1'b1; sam_clk_en = 1'b0; sym_clk_en = 1'b0; phase_sel = 1'b0;
    x_in = '0; pend_vld = 1'b0; pend_sym = '0; pend_blk = 1'b0;
    ideal_x = '{18'sd98304, 18'sd32768, -18'sd32768, -18'sd98304};
    ideal_s = '{2'b10, 2'b11, 2'b01, 2'b00};

    do_reset();

    // Partial block of full-scale negatives, then reset mid-block.
    for (int i = 0; i < 9; i++) symbol(18'sh20000, 18'sh20000, 2'b00, 1'b0);
    flush();
    do_reset();

    // Ideal levels for two blocks; first blk_done exactly 16 symbols after release.
    for (int i = 0; i < 16; i++) symbol(18'sd0, ideal_x[i%4], ideal_s[i%4], 1'(i == 15));
    flush();
    chk("ideal1 ref_level", 64'(ref_level), 64'(65536));
    chk("ideal1 err_pow", 64'(err_pow), 64'(0));
    chk("ideal1 locked", 64'(locked), 64'(1));
    for (int i = 0; i < 16; i++) symbol(18'sd0, ideal_x[i%4], ideal_s[i%4], 1'(i == 15));
    flush();
    chk("ideal2 ref_level", 64'(ref_level), 64'(65536));
    chk("ideal2 err_pow", 64'(err_pow), 64'(0));

    // Constant input exactly at the initial threshold: outer decision.
    do_reset();
    for (int i = 0; i < 16; i++) symbol(18'sd65536, 18'sd65536, 2'b10, 1'(i == 15));
    flush();
    chk("tie ref_level", 64'(ref_level), 64'(65536));
    chk("tie err_pow", 64'(err_pow), 64'(1073741824));
    chk("tie locked", 64'(locked), 64'(1));

    // Phase select and threshold boundaries at t=65536.
    phase_sel = 1'b1;
    for (int i = 0; i < 4; i++) symbol(18'sd98304, -18'sd32768, 2'b10, 1'b0);
    phase_sel = 1'b0;
    for (int i = 0; i < 4; i++) symbol(18'sd98304, -18'sd32768, 2'b01, 1'b0);
    symbol(18'sd0, -18'sd65536, 2'b00, 1'b0);
    symbol(18'sd0, -18'sd65535, 2'b01, 1'b0);
    symbol(18'sd0, 18'sd65535, 2'b11, 1'b0);
    flush();

    // Full-scale negative: |x| saturates, threshold reaches 131071.
    do_reset();
    for (int i = 0; i < 16; i++) symbol(18'sh20000, 18'sh20000, 2'b00, 1'(i == 15));
    flush();
    chk("fs ref_level", 64'(ref_level), 64'(131071));
    chk("fs err_pow", 64'(err_pow), 64'(1073741824));
    chk("fs locked", 64'(locked), 64'(1));
    symbol(18'sd0, 18'sd131071, 2'b10, 1'b0);
    symbol(18'sd0, 18'sd131070, 2'b11, 1'b0);
    symbol(18'sd0, -18'sd131071, 2'b00, 1'b0);
    flush();

`ifdef DC_REMOVE_EN
    do_reset();
    for (int i = 0; i < 16; i++) begin
      v = ideal_x[i%4] + 18'sd8192;
      symbol(18'sd0, v, ideal_s[i%4], 1'(i == 15));
    end
    flush();
    chk("dc1 dc_est", 64'(dc_est), 64'(8192));
    chk("dc1 ref_level", 64'(ref_level), 64'(65536));
    chk("dc1 err_pow", 64'(err_pow), 64'(67108864));
    for (int i = 0; i < 16; i++) begin
      v = ideal_x[i%4] + 18'sd8192;
      symbol(18'sd0, v, ideal_s[i%4], 1'(i == 15));
    end
    flush();
    chk("dc2 dc_est", 64'(dc_est), 64'(8192));
    chk("dc2 ref_level", 64'(ref_level), 64'(65536));
    chk("dc2 err_pow", 64'(err_pow), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ask4_slicer_mer.md
Name: ask4_slicer_mer

Overview:
- Symbol-rate 4-ASK decision slicer and error-power estimator.
- Sits directly downstream of the halfband decimator. Consumes its 1s17 output at the sample rate (2 samples/symbol) and keeps one sample per symbol.
- Estimates the decision threshold from block-averaged |x|, emits Gray-coded decisions, and reports mean squared slicer error per block for MER measurement.

Parameters:
- LOG2_N, 7, log2 of the averaging block length in symbols (N = 2^LOG2_N).
- INIT_REF, 65536, threshold used before the first block completes (1s17, i.e. 0.5).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sam_clk_en  in  1  one-cycle strobe, sample rate
- sym_clk_en  in  1  one-cycle strobe, symbol rate; always coincides with a sam_clk_en
- phase_sel  in  1  0: symbol sample = x_in at sym_clk_en; 1: previous sample
- x_in  in  18  decimator output, signed 1s17
- sym_out  out  2  Gray decision: -3b=00, -b=01, +b=11, +3b=10
- sym_valid  out  1  one-cycle pulse when sym_out updates
- ref_level  out  18  current threshold, signed 1s17, always >= 0
- err_pow  out  36  mean squared error of last block, unsigned 2s34
- blk_done  out  1  one-cycle pulse when ref_level/err_pow update
- locked  out  1  0 in ACQ, 1 in TRACK

Behaviour:
- Reset values: sym_out=00, sym_valid=0, ref_level=INIT_REF, err_pow=0, blk_done=0, locked=0, all accumulators/counters 0, state ACQ.
- x_prev loads x_in on every sam_clk_en.
- On sym_clk_en, the symbol sample s = phase_sel ? x_prev : x_in. s is registered as s_r (cycle T+1).
- Slice, cycle T+2 (sym_valid high for exactly that cycle):
  - t = ref_level.
  - s_r >= 0 and s_r >= t -> 10; s_r >= 0 and s_r < t -> 11; s_r < 0 and s_r > -t -> 01; otherwise -> 00.
  - Ties go outward (|s| = t is an outer decision).
- Reconstructed level: b = t>>>1; outer = t + b. Compute in 19-bit 2s17 (no overflow).
- Error: e = s_r - level, 19-bit 2s17. e^2 is 38-bit 4s34 unsigned.
- Accumulators, updated in the slice cycle:
  - abs_acc += |s_r|. |-131072| saturates to 131071. Width 17+LOG2_N.
  - sq_acc += e^2. Saturates at all-ones. Width 38+LOG2_N.
- Symbol counter: LOG2_N bits, increments per slice. On the wrap from N-1 to 0 (the final symbol is included in its own block), in the same cycle:
  - ref_level <= abs_acc_next >> LOG2_N (lower 17 bits, sign 0).
  - err_pow <= min(sq_acc_next >> LOG2_N, 2^36-1).
  - Accumulators clear to 0 for the next block. blk_done pulses. State ACQ -> TRACK.
- State machine: ACQ (threshold INIT_REF, locked=0) -> TRACK after the first block. TRACK stays in TRACK, updating every block; leaves only via reset.
- sym_clk_en without sam_clk_en: ignored (protocol violation; flagged by assertion).
- Reset mid-block: partial accumulators are discarded; behaviour restarts exactly as after power-up.
- Total latency sym_clk_en -> sym_out: 2 clk.

Optional Feature:
- Macro DC_REMOVE_EN.
- Defined:
  - A third accumulator sums signed s_r per block. dc = sum>>LOG2_N is latched at block end (0 after reset).
  - Slicing and error use s_r - dc, saturated to 1s17. |x| accumulation uses the corrected value.
  - Extra output port dc_est (18, 1s17).
- Undefined: no dc accumulator, no dc_est port, slicing on raw s_r; behaviour identical to the base description.

Decomposition:
- Shared package ask_pkg:
  - 1s17 sample width constant.
  - Gray symbol codes (SYM_M3, SYM_M1, SYM_P1, SYM_P3).
  - State enum {ACQ, TRACK}.
  - Saturating abs/clip helper functions.
- One natural sub-module, block_avg_acc: a parameterised saturating accumulator with wrap-load-clear. Instanced for |x|, e^2, and optionally dc.

Test Plan (bench LOG2_N=4, N=16; sym_clk_en every 4 clk, sam_clk_en every 2 clk):
- Reset asserted mid-block after 9 symbols -> all outputs at reset values. The next blk_done comes exactly 16 symbols after release.
- Ideal 4-ASK cycling ±32768/±98304 for 32 symbols:
  - First block_done: ref_level=65536, err_pow=0.
  - locked=1.
  - sym_out matches the Gray map with 2-clk latency.
- Constant x_in=+65536 (exactly at INIT_REF) in ACQ -> sym_out=10 (tie goes outer). After the block: ref_level=65536, err_pow = (65536-98304)^2>>0 scaled = 1073741824 in 2s34.
- phase_sel=1 with the alternating pattern sample0=+98304, sample1=-32768 -> decisions use x_prev (+98304 -> 10). phase_sel=0 -> 01.
- x_in=-131072 for 16 symbols -> abs saturates to 131071, ref_level=131071, no wrap, err_pow nonzero and finite.
- DC_REMOVE_EN with an ideal pattern offset by +8192 -> after block 1 dc_est=8192. Block 2 err_pow=0, ref_level=65536.
